// File: rtl/multi_scaler_generator.sv
// multi_scaler_generator: per-channel scaler flag generator with stuck-on detection
// and PULSE / MASK / PASS handling of stuck channels.
module multi_scaler_generator #(
    parameter int NUM_CH = 8,
    parameter int CNT_W  = 4
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [NUM_CH-1:0] trig_i,
    input  logic              sce_i,
    input  logic              sync_i,
    input  logic [CNT_W-1:0]  thresh_i,
    input  logic [1:0]        mode_i,
    input  logic              clr_latch_i,
    output logic [NUM_CH-1:0] scaler_o,
    output logic [NUM_CH-1:0] stuck_o,
    output logic [NUM_CH-1:0] stuck_latch_o,
    output logic              stuck_new_o
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NUM_CH-1:0] trig_q;
    logic [NUM_CH-1:0] all_high;
    logic [NUM_CH-1:0] edge_v;
    logic [NUM_CH-1:0] bad;
    logic [NUM_CH-1:0] stuck_next;
    logic [NUM_CH-1:0] scaler_next;
    logic [CNT_W-1:0]  cnt [NUM_CH];

    always_comb begin
        stuck_next  = '0;
        scaler_next = '0;
        edge_v      = trig_i & ~trig_q;
        bad         = all_high & trig_i & {NUM_CH{sce_i}};
        for (int n = 0; n < NUM_CH; n++) begin
            stuck_next[n]  = (thresh_i != '0) && (cnt[n] >= thresh_i);
            // mode_i[1] set means PASS; MASK drops everything on a stuck channel
            scaler_next[n] = (!stuck_o[n] || mode_i[1]) ? edge_v[n] :
                             (mode_i == 2'd0) ? (edge_v[n] | sync_i) : 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            trig_q        <= '0;
            all_high      <= '0;
            scaler_o      <= '0;
            stuck_o       <= '0;
            stuck_latch_o <= '0;
            stuck_new_o   <= 1'b0;
            for (int n = 0; n < NUM_CH; n++) cnt[n] <= '0;
        end else begin
            trig_q        <= trig_i;
            all_high      <= sce_i ? '1 : (all_high & trig_i);
            for (int n = 0; n < NUM_CH; n++)
                if (sce_i) cnt[n] <= !bad[n] ? '0 : (cnt[n] == CNT_MAX) ? cnt[n] : cnt[n] + 1'b1;
            stuck_o       <= stuck_next;
            stuck_new_o   <= |(stuck_next & ~stuck_o);
            stuck_latch_o <= (stuck_latch_o & ~{NUM_CH{clr_latch_i}}) | stuck_next;
            scaler_o      <= scaler_next;
        end
    end
endmodule

// File: tb/tb_multi_scaler_generator.sv
// tb_multi_scaler_generator: directed scenarios plus randomized traffic, checked every
// cycle against a window-counting reference model.
module tb_multi_scaler_generator;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] trig = '0;
    logic       sce = 1'b0, sync = 1'b0, clr = 1'b0;
    logic [3:0] thresh = '0;
    logic [1:0] mode = 2'd2;
    logic [7:0] scaler, stuck, latch;
    logic       stuck_new;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_prev, m_clean, m_stuck, m_latch, m_scaler;
    logic       m_new;
    int         m_wins [8];

    multi_scaler_generator #(.NUM_CH(8), .CNT_W(4)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .trig_i(trig), .sce_i(sce), .sync_i(sync),
        .thresh_i(thresh), .mode_i(mode), .clr_latch_i(clr),
        .scaler_o(scaler), .stuck_o(stuck), .stuck_latch_o(latch), .stuck_new_o(stuck_new)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_prev = '0; m_clean = '0; m_stuck = '0; m_latch = '0; m_scaler = '0; m_new = 1'b0;
        for (int n = 0; n < 8; n++) m_wins[n] = 0;
    endtask

    // m_clean[n]: current window began after an sce and the channel has been high every cycle so far;
    // m_wins[n]: number of consecutive fully-high windows, capped at 15.
    task automatic cyc();
        logic [7:0] sn, sc, rise;
        sn = '0; sc = '0;
        rise = trig & ~m_prev;
        for (int n = 0; n < 8; n++) begin
            sn[n] = (thresh != 0) && (m_wins[n] >= int'(thresh));
            if (!m_stuck[n] || mode >= 2) sc[n] = rise[n];
            else if (mode == 0)           sc[n] = rise[n] | sync;
            else                          sc[n] = 1'b0;
            if (sce) begin
                m_wins[n]  = (m_clean[n] && trig[n]) ? ((m_wins[n] + 1 > 15) ? 15 : m_wins[n] + 1) : 0;
                m_clean[n] = 1'b1;
            end else begin
                m_clean[n] = m_clean[n] && trig[n];
            end
        end
        m_new    = (sn & ~m_stuck) != 0;
        m_latch  = (clr ? 8'h00 : m_latch) | sn;
        m_stuck  = sn;
        m_scaler = sc;
        m_prev   = trig;
        @(posedge clk);
        #1;
        chk("scaler", scaler, m_scaler);
        chk("stuck", stuck, m_stuck);
        chk("latch", latch, m_latch);
        chk("stuck_new", stuck_new, m_new);
    endtask

    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_scaler", scaler, 0);
        chk("rst_stuck", stuck, 0);
        chk("rst_latch", latch, 0);
        chk("rst_new", stuck_new, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        model_reset();
    endtask

    task automatic windows(input int count, input int period);
        for (int w = 0; w < count; w++) begin
            for (int i = 0; i < period - 1; i++) begin sce = 0; cyc(); end
            sce = 1; cyc(); sce = 0;
        end
    endtask

    initial begin
        logic [7:0] lvl;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("init_scaler", scaler, 0);
        chk("init_stuck", stuck, 0);
        @(negedge clk) rst_n = 1'b1;

        // single-cycle pulse on ch0 in PASS mode
        trig = 8'h01; cyc(); chk("t1_rise", scaler, 8'h01);
        trig = 8'h00; cyc(); chk("t1_fall", scaler, 8'h00);

        // ch2 held high, thresh 3, sce every 16 cycles
        thresh = 3; trig = 8'h04;
        windows(4, 16);
        chk("t2_not_yet", stuck[2], 0);
        cyc();
        chk("t2_stuck", stuck[2], 1);
        chk("t2_new", stuck_new, 1);
        chk("t2_latch", latch[2], 1);
        cyc();
        chk("t2_new_once", stuck_new, 0);

        // PULSE mode: sync every 4 cycles, sce keeps windows going
        mode = 0;
        for (int i = 0; i < 16; i++) begin
            sync = (i % 4 == 0); sce = (i == 15); cyc();
            if (i % 4 == 0) chk("t3_pulse", scaler[2], 1);
        end
        sync = 0; sce = 0;
        mode = 1;
        for (int i = 0; i < 16; i++) begin
            sync = (i % 4 == 0); sce = (i == 15); cyc();
            chk("t3_mask", scaler[2], 0);
        end
        sync = 0; sce = 0;

        // one low cycle mid-window releases ch2
        mode = 2;
        repeat (5) cyc();
        trig = 8'h00; cyc();
        trig = 8'h04; repeat (5) cyc();
        sce = 1; cyc(); sce = 0;
        chk("t4_still", stuck[2], 1);
        cyc();
        chk("t4_release", stuck[2], 0);
        chk("t4_latch_hold", latch[2], 1);
        clr = 1; cyc(); clr = 0;
        chk("t4_latch_clr", latch[2], 0);

        // thresh 0 disables detection while the counter saturates
        thresh = 0;
        windows(20, 2);
        chk("t5_disabled", stuck, 0);
        thresh = 15; cyc();
        chk("t5_enable", stuck[2], 1);

        // async reset while stuck, then a full re-qualification
        thresh = 3;
        async_reset();
        windows(3, 4);
        cyc();
        chk("t6_not_yet", stuck[2], 0);
        windows(1, 4);
        cyc();
        chk("t6_stuck", stuck[2], 1);

        // randomized traffic
        lvl = 8'h0f;
        for (int i = 0; i < 4000; i++) begin
            for (int n = 0; n < 8; n++) if ($urandom_range(0, 23) == 0) lvl[n] = ~lvl[n];
            trig = lvl;
            if ($urandom_range(0, 39) == 0) trig[$urandom_range(0, 7)] ^= 1'b1;
            sce  = ($urandom_range(0, 3) == 0);
            sync = ($urandom_range(0, 3) == 0);
            clr  = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 199) == 0) begin
                case ($urandom_range(0, 4))
                    0: thresh = 0;
                    1: thresh = 1;
                    2: thresh = 2;
                    3: thresh = 3;
                    default: thresh = 15;
                endcase
            end
            if ($urandom_range(0, 599) == 0) async_reset();
            else cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
